// File: rtl/freq_div_pkg.sv
// Shared constants and config legality rule for the programmable divider.
// Pure package: no state, no latency, no flow control.
package freq_div_pkg;

  localparam int FD_W            = 16;
  localparam int FD_DEFAULT_DIV  = 4;
  localparam int FD_DEFAULT_HIGH = 2;
  // Legality check runs at this width; W may not exceed it.
  localparam int FD_MAX_W        = 32;

  function automatic logic cfg_legal(input logic [FD_MAX_W-1:0] div,
                                     input logic [FD_MAX_W-1:0] high);
    return (div >= FD_MAX_W'(2)) && (high >= FD_MAX_W'(1)) && (high < div);
  endfunction

endpackage

// File: rtl/freq_div_cfg_slot.sv
// One-entry config slot: legality check, pending divisor/high-time, sticky cfg_err.
// Entry visible one cycle after transfer; cfg_ready is low while the entry waits to be applied.
module freq_div_cfg_slot
  import freq_div_pkg::*;
#(
  parameter int W = FD_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         cfg_valid,
  output logic         cfg_ready,
  input  logic [W-1:0] div_value,
  input  logic [W-1:0] high_value,
  input  logic         cfg_err_clr,
  input  logic         apply,
  output logic         pend_vld,
  output logic [W-1:0] pend_div,
  output logic [W-1:0] pend_high,
  output logic         cfg_err
);

  logic         pend_vld_q, pend_vld_d;
  logic [W-1:0] pend_div_q, pend_div_d;
  logic [W-1:0] pend_high_q, pend_high_d;
  logic         cfg_err_q, cfg_err_d;
  logic         xfer;
  logic         legal;

  always_comb begin
    xfer        = cfg_valid && !pend_vld_q;
    legal       = cfg_legal(FD_MAX_W'(div_value), FD_MAX_W'(high_value));
    pend_vld_d  = pend_vld_q;
    pend_div_d  = pend_div_q;
    pend_high_d = pend_high_q;
    // apply only fires with an entry held, xfer only with the slot empty
    if (apply) pend_vld_d = 1'b0;
    if (xfer && legal) begin
      pend_vld_d  = 1'b1;
      pend_div_d  = div_value;
      pend_high_d = high_value;
    end
    cfg_err_d = cfg_err_q;
    if (cfg_err_clr) cfg_err_d = 1'b0;
    if (xfer && !legal) cfg_err_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_vld_q  <= 1'b0;
      pend_div_q  <= '0;
      pend_high_q <= '0;
      cfg_err_q   <= 1'b0;
    end else begin
      pend_vld_q  <= pend_vld_d;
      pend_div_q  <= pend_div_d;
      pend_high_q <= pend_high_d;
      cfg_err_q   <= cfg_err_d;
    end
  end

  assign cfg_ready = !pend_vld_q;
  assign pend_vld  = pend_vld_q;
  assign pend_div  = pend_div_q;
  assign pend_high = pend_high_q;
  assign cfg_err   = cfg_err_q;

endmodule

// File: rtl/freq_divider_prog.sv
// Runtime-programmable divider: registered clock_out/tick one cycle behind the counter.
// Config accepted when cfg_ready; new settings swap in only at a period boundary.
module freq_divider_prog
  import freq_div_pkg::*;
#(
  parameter int W            = FD_W,
  parameter int DEFAULT_DIV  = FD_DEFAULT_DIV,
  parameter int DEFAULT_HIGH = FD_DEFAULT_HIGH
) (
  input  logic         clock_in,
  input  logic         reset,
  input  logic         enable,
  input  logic         cfg_valid,
  output logic         cfg_ready,
  input  logic [W-1:0] div_value,
  input  logic [W-1:0] high_value,
  input  logic         cfg_err_clr,
  output logic         clock_out,
  output logic         tick,
  output logic         cfg_err
);

  if (DEFAULT_DIV < 2 || DEFAULT_HIGH < 1 || DEFAULT_HIGH >= DEFAULT_DIV) begin : g_bad_default
    $fatal(1, "freq_divider_prog: illegal DEFAULT_DIV/DEFAULT_HIGH");
  end
  if (W < 2 || W > FD_MAX_W || longint'(DEFAULT_DIV) >= (longint'(1) << W)) begin : g_bad_width
    $fatal(1, "freq_divider_prog: W cannot hold DEFAULT_DIV");
  end

  localparam logic [W-1:0] DIV_RST  = W'(DEFAULT_DIV);
  localparam logic [W-1:0] HIGH_RST = W'(DEFAULT_HIGH);

  logic [W-1:0] c_q, c_d;
  logic [W-1:0] div_act_q, div_act_d;
  logic [W-1:0] high_act_q, high_act_d;
  logic         clock_out_q, clock_out_d;
  logic         tick_q, tick_d;
  logic         wrap;
  logic         apply;
  logic         pend_vld;
  logic [W-1:0] pend_div;
  logic [W-1:0] pend_high;

  freq_div_cfg_slot #(.W(W)) u_cfg_slot (
    .clk         (clock_in),
    .rst         (reset),
    .cfg_valid   (cfg_valid),
    .cfg_ready   (cfg_ready),
    .div_value   (div_value),
    .high_value  (high_value),
    .cfg_err_clr (cfg_err_clr),
    .apply       (apply),
    .pend_vld    (pend_vld),
    .pend_div    (pend_div),
    .pend_high   (pend_high),
    .cfg_err     (cfg_err)
  );

  always_comb begin
    wrap  = (c_q == div_act_q - W'(1));
    // While disabled the counter sits at 0, so any boundary is a safe swap point
    apply = pend_vld && (!enable || wrap);
    c_d   = '0;
    if (enable && !wrap) c_d = c_q + W'(1);
    div_act_d  = div_act_q;
    high_act_d = high_act_q;
    if (apply) begin
      div_act_d  = pend_div;
      high_act_d = pend_high;
    end
    clock_out_d = enable && (c_q < high_act_q);
    tick_d      = enable && (c_q == '0);
  end

  always_ff @(posedge clock_in or posedge reset) begin
    if (reset) begin
      c_q         <= '0;
      div_act_q   <= DIV_RST;
      high_act_q  <= HIGH_RST;
      clock_out_q <= 1'b0;
      tick_q      <= 1'b0;
    end else begin
      c_q         <= c_d;
      div_act_q   <= div_act_d;
      high_act_q  <= high_act_d;
      clock_out_q <= clock_out_d;
      tick_q      <= tick_d;
    end
  end

  assign clock_out = clock_out_q;
  assign tick      = tick_q;

endmodule

// File: tb/tb_freq_divider_prog.sv
// Bench for freq_divider_prog: period-level reference model plus directed literal sequences.
module tb_freq_divider_prog;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en = 1'b0;
  logic        cfg_valid = 1'b0;
  logic [15:0] div_value = '0;
  logic [15:0] high_value = '0;
  logic        cfg_err_clr = 1'b0;
  logic        cfg_ready, clock_out, tick, cfg_err;

  logic        cfg_valid2 = 1'b0;
  logic [3:0]  div_value2 = '0;
  logic [3:0]  high_value2 = '0;
  logic        cfg_err_clr2 = 1'b0;
  logic        cfg_ready2, clock_out2, tick2, cfg_err2;

  int n_chk = 0;
  int n_err = 0;
  bit chk_on = 0;

  always #5 clk = ~clk;

  freq_divider_prog dut (
    .clock_in(clk), .reset(rst), .enable(en),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .div_value(div_value), .high_value(high_value), .cfg_err_clr(cfg_err_clr),
    .clock_out(clock_out), .tick(tick), .cfg_err(cfg_err)
  );

  freq_divider_prog #(.W(4), .DEFAULT_DIV(4), .DEFAULT_HIGH(2)) dut_w4 (
    .clock_in(clk), .reset(rst), .enable(en),
    .cfg_valid(cfg_valid2), .cfg_ready(cfg_ready2),
    .div_value(div_value2), .high_value(high_value2), .cfg_err_clr(cfg_err_clr2),
    .clock_out(clock_out2), .tick(tick2), .cfg_err(cfg_err2)
  );

  // Reference model: position within the period, active and queued settings
  int pos = 0, per = 4, hi = 2;
  int q_div[$];
  int q_high[$];
  bit m_err = 0, e_clk = 0, e_tick = 0;
  int old_pos, old_per;
  bit held, boundary;

  function automatic bit legal(input int d, input int h);
    return d >= 2 && h >= 1 && h < d;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      pos = 0; per = 4; hi = 2; m_err = 0; e_clk = 0; e_tick = 0;
      q_div.delete(); q_high.delete();
    end else begin
      old_pos  = pos;
      old_per  = per;
      held     = (q_div.size() != 0);
      e_clk    = en && (old_pos < hi);
      e_tick   = en && (old_pos == 0);
      boundary = !en || (old_pos == old_per - 1);
      pos      = en ? (old_pos + 1) % old_per : 0;
      if (held && boundary) begin
        per = q_div.pop_front();
        hi  = q_high.pop_front();
      end
      if (cfg_err_clr) m_err = 0;
      if (cfg_valid && !held) begin
        if (legal(int'(div_value), int'(high_value))) begin
          q_div.push_back(int'(div_value));
          q_high.push_back(int'(high_value));
        end else begin
          m_err = 1;
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      chk("model/clock_out", 32'(clock_out), 32'(e_clk));
      chk("model/tick", 32'(tick), 32'(e_tick));
      chk("model/cfg_ready", 32'(cfg_ready), 32'(q_div.size() == 0));
      chk("model/cfg_err", 32'(cfg_err), 32'(m_err));
    end
  end

  task automatic step();
    @(negedge clk);
  endtask

  // Literal sequences, oldest sample in the MSB of the n-bit vector
  task automatic run_seq(input string nm, input int n, input logic [15:0] ec,
                         input logic [15:0] et, input logic [15:0] er);
    for (int i = 0; i < n; i++) begin
      step();
      chk({nm, "/clock_out"}, 32'(clock_out), 32'(ec[n-1-i]));
      chk({nm, "/tick"}, 32'(tick), 32'(et[n-1-i]));
      chk({nm, "/cfg_ready"}, 32'(cfg_ready), 32'(er[n-1-i]));
    end
  endtask

  task automatic send(input int d, input int h, input bit clr);
    cfg_valid = 1'b1; div_value = 16'(d); high_value = 16'(h); cfg_err_clr = clr;
    step();
    cfg_valid = 1'b0; cfg_err_clr = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int cnt;
    bit found;
    #1 rst = 1'b1;
    chk_on = 1;
    step(); step();
    chk("reset/clock_out", 32'(clock_out), 0);
    chk("reset/tick", 32'(tick), 0);
    chk("reset/cfg_ready", 32'(cfg_ready), 1);
    chk("reset/cfg_err", 32'(cfg_err), 0);
    rst = 1'b0;
    step();
    en = 1'b1;
    run_seq("default", 8, 8'b11001100, 8'b10001000, 8'hFF);

    // Load 5/1 while the counter sits at 1
    step();
    send(5, 1, 0);
    chk("load/ready_low", 32'(cfg_ready), 0);
    chk("load/clock_out_old", 32'(clock_out), 1);
    run_seq("div5", 11, 11'b00100001000, 11'b00100001000, 11'b01111111111);

    // Illegal settings, then set-beats-clear
    send(1, 1, 0);
    chk("illegal_div1/err", 32'(cfg_err), 1);
    chk("illegal_div1/ready", 32'(cfg_ready), 1);
    cfg_err_clr = 1'b1; step(); cfg_err_clr = 1'b0;
    chk("clr1/err", 32'(cfg_err), 0);
    send(6, 0, 0);
    chk("illegal_high0/err", 32'(cfg_err), 1);
    cfg_err_clr = 1'b1; step(); cfg_err_clr = 1'b0;
    chk("clr2/err", 32'(cfg_err), 0);
    send(6, 6, 0);
    chk("illegal_high_eq_div/err", 32'(cfg_err), 1);
    send(6, 6, 1);
    chk("set_wins/err", 32'(cfg_err), 1);
    cfg_err_clr = 1'b1; step(); cfg_err_clr = 1'b0;
    chk("clr3/err", 32'(cfg_err), 0);

    // Disable at c=2, reprogram while idle, re-enable
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (pos == 2) found = 1; else step();
    end
    chk("find_c2", 32'(found), 1);
    en = 1'b0;
    run_seq("disabled", 3, 3'b000, 3'b000, 3'b111);
    send(3, 2, 0);
    chk("idle_load/ready_low", 32'(cfg_ready), 0);
    step();
    chk("idle_load/ready_back", 32'(cfg_ready), 1);
    chk("idle_load/clock_out", 32'(clock_out), 0);
    en = 1'b1;
    run_seq("reenable", 6, 6'b110110, 6'b100100, 6'b111111);

    // Reset with a config pending
    send(5, 1, 0);
    chk("pend/ready_low", 32'(cfg_ready), 0);
    chk("pend/clock_out", 32'(clock_out), 1);
    #1 rst = 1'b1;
    #1;
    chk("async_rst/clock_out", 32'(clock_out), 0);
    chk("async_rst/tick", 32'(tick), 0);
    chk("async_rst/cfg_ready", 32'(cfg_ready), 1);
    step();
    rst = 1'b0;
    run_seq("post_reset", 8, 8'b11001100, 8'b10001000, 8'hFF);

    // W=4 instance at the largest divisor
    chk("w4/ready", 32'(cfg_ready2), 1);
    cfg_valid2 = 1'b1; div_value2 = 4'd15; high_value2 = 4'd14;
    step();
    cfg_valid2 = 1'b0;
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      step();
      if (cfg_ready2) found = 1;
    end
    chk("w4/applied", 32'(found), 1);
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (tick2) found = 1; else step();
    end
    chk("w4/tick_seen", 32'(found), 1);
    chk("w4/first_high", 32'(clock_out2), 1);
    cnt = 32'(clock_out2);
    for (int i = 1; i < 15; i++) begin
      step();
      cnt += 32'(clock_out2);
      if (tick2) chk("w4/no_early_tick", 32'(i), 15);
    end
    chk("w4/last_low", 32'(clock_out2), 0);
    chk("w4/high_count", 32'(cnt), 14);
    step();
    chk("w4/next_tick", 32'(tick2), 1);
    chk("w4/next_high", 32'(clock_out2), 1);
    chk("w4/err", 32'(cfg_err2), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
